// File: rtl/riscv_defines.sv
// Shared definitions for the core datapath.
// Holds the string-operation codes used by riscv_str_ops and its sequencer,
// the sequencer state encoding, and the sequencer default word limit.
package riscv_defines;

  // Operation codes understood by riscv_str_ops
  localparam int                    STR_OP_WIDTH = 2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_COPY  = 2'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_SWAP  = 2'd3;

  // Default word limit for one string command
  localparam int STR_SEQ_MAX_WORDS = 256;

  typedef enum logic [2:0] {
    STR_SEQ_IDLE,
    STR_SEQ_RD_REQ,
    STR_SEQ_RD_WAIT,
    STR_SEQ_SCAN,
    STR_SEQ_WR_REQ,
    STR_SEQ_WR_WAIT,
    STR_SEQ_DONE
  } str_seq_state_e;

endpackage

// File: rtl/riscv_str_ops_seq.sv
// Multi-cycle string-op sequencer.
// Walks a NUL-terminated string one 32-bit word at a time: reads a word,
// presents it to riscv_str_ops, and writes the result back with byte enables
// covering only the bytes before the terminator.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   start_i             command strobe (accepted only when idle)
//   operator_i, addr_i  operation and string base (bits [1:0] ignored)
//   busy_o, done_o      command in flight / one-cycle completion pulse
//   err_o, limit_o      bus error / word limit reached (held until next accept)
//   count_o             words written back (held until next accept)
//   data_*              dedicated data-memory port (req/gnt/rvalid protocol)
//   strop_*             connection to the riscv_str_ops unit
module riscv_str_ops_seq
  import riscv_defines::*;
#(
  parameter int MAX_WORDS = STR_SEQ_MAX_WORDS,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    limit_o,
  output logic [CNT_WIDTH-1:0]    count_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic                    data_err_i,
  output logic [31:0]             data_addr_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [31:0]             data_wdata_o,
  input  logic [31:0]             data_rdata_i,
  output logic                    strop_en_o,
  output logic [STR_OP_WIDTH-1:0] strop_operator_o,
  output logic [31:0]             strop_operand_o,
  input  logic [31:0]             strop_result_i
);

  // Byte enables for the bytes that precede the first NUL (byte 0 first).
  // All ones means no NUL in the word; all zeros means NUL in byte 0.
  function automatic logic [3:0] nul_be(input logic [31:0] word);
    logic [3:0] be;
    logic       found;
    be    = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found) begin
        if (word[8*i +: 8] == 8'h00) found = 1'b1;
        else                         be[i] = 1'b1;
      end
    end
    return be;
  endfunction

  str_seq_state_e          state_q, state_d;
  logic [STR_OP_WIDTH-1:0] op_q;
  logic [31:0]             addr_q;
  logic [31:0]             operand_q;
  logic [3:0]              be_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [CNT_WIDTH-1:0]    count_inc;
  logic                    err_q;
  logic                    limit_q;
  logic                    addr_lsb_unused;

  // The base is forced to a word boundary, so the low address bits are dropped
  assign addr_lsb_unused = ^addr_i[1:0];
  assign count_inc       = count_q + CNT_WIDTH'(1);

  // State register and command context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STR_SEQ_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      be_q      <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        STR_SEQ_IDLE: begin
          if (start_i) begin
            op_q    <= operator_i;
            addr_q  <= {addr_i[31:2], 2'b00};
            count_q <= '0;
            err_q   <= 1'b0;
            limit_q <= 1'b0;
          end
        end
        STR_SEQ_RD_WAIT: begin
          if (data_rvalid_i) begin
            // An errored read leaves the previous operand in place
            if (data_err_i) err_q     <= 1'b1;
            else            operand_q <= data_rdata_i;
          end
        end
        STR_SEQ_SCAN: be_q <= nul_be(operand_q);
        STR_SEQ_WR_WAIT: begin
          if (data_rvalid_i) begin
            if (data_err_i) begin
              err_q <= 1'b1;
            end else begin
              count_q <= count_inc;
              // A full word means the string continues past this word
              if (be_q == 4'hF) begin
                if (count_inc == CNT_WIDTH'(MAX_WORDS)) limit_q <= 1'b1;
                else                                   addr_q  <= addr_q + 32'd4;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and memory-port drive
  always_comb begin
    state_d      = state_q;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = 4'h0;
    data_wdata_o = 32'h0;
    strop_en_o   = 1'b0;
    case (state_q)
      STR_SEQ_IDLE: if (start_i) state_d = STR_SEQ_RD_REQ;
      STR_SEQ_RD_REQ: begin
        data_req_o = 1'b1;
        data_be_o  = 4'hF;
        if (data_gnt_i) state_d = STR_SEQ_RD_WAIT;
      end
      STR_SEQ_RD_WAIT: begin
        if (data_rvalid_i) state_d = data_err_i ? STR_SEQ_DONE : STR_SEQ_SCAN;
      end
      STR_SEQ_SCAN: begin
        state_d = (nul_be(operand_q) == 4'h0) ? STR_SEQ_DONE : STR_SEQ_WR_REQ;
      end
      STR_SEQ_WR_REQ: begin
        // Operand and operator are registered, so the result is stable until gnt
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_be_o    = be_q;
        data_wdata_o = strop_result_i;
        strop_en_o   = 1'b1;
        if (data_gnt_i) state_d = STR_SEQ_WR_WAIT;
      end
      STR_SEQ_WR_WAIT: begin
        if (data_rvalid_i) begin
          if (data_err_i || be_q != 4'hF)              state_d = STR_SEQ_DONE;
          else if (count_inc == CNT_WIDTH'(MAX_WORDS)) state_d = STR_SEQ_DONE;
          else                                         state_d = STR_SEQ_RD_REQ;
        end
      end
      STR_SEQ_DONE: state_d = STR_SEQ_IDLE;
      default:      state_d = STR_SEQ_IDLE;
    endcase
  end

  assign busy_o           = (state_q != STR_SEQ_IDLE) && (state_q != STR_SEQ_DONE);
  assign done_o           = (state_q == STR_SEQ_DONE);
  assign err_o            = err_q;
  assign limit_o          = limit_q;
  assign count_o          = count_q;
  assign data_addr_o      = addr_q;
  assign strop_operator_o = op_q;
  assign strop_operand_o  = operand_q;

endmodule

// File: tb/tb_riscv_str_ops_seq.sv
// Self-checking bench for riscv_str_ops_seq.
// Provides a behavioural riscv_str_ops unit, a randomly delayed data memory,
// and a string-walking reference model of the command.
module tb_riscv_str_ops_seq;
  import riscv_defines::*;

  localparam int MAXW = 2;
  localparam int CW   = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start_i;
  logic [STR_OP_WIDTH-1:0] operator_i;
  logic [31:0]             addr_i;
  logic                    busy_o, done_o, err_o, limit_o;
  logic [CW-1:0]           count_o;
  logic                    data_req_o, data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0]             data_addr_o, data_wdata_o, data_rdata_i;
  logic                    data_we_o;
  logic [3:0]              data_be_o;
  logic                    strop_en_o;
  logic [STR_OP_WIDTH-1:0] strop_operator_o;
  logic [31:0]             strop_operand_o, strop_result_i;

  always #5 clk = ~clk;

  riscv_str_ops_seq #(.MAX_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .operator_i(operator_i), .addr_i(addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .limit_o(limit_o), .count_o(count_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .strop_en_o(strop_en_o), .strop_operator_o(strop_operator_o),
    .strop_operand_o(strop_operand_o), .strop_result_i(strop_result_i)
  );

  int vectors = 0;
  int miscompares = 0;

  // Character transform of the string unit
  function automatic logic [7:0] op_byte(input logic [STR_OP_WIDTH-1:0] op, input logic [7:0] b);
    bit lo, up;
    lo = (b >= 8'h61) && (b <= 8'h7A);
    up = (b >= 8'h41) && (b <= 8'h5A);
    case (op)
      STR_OP_UPPER: return lo ? b - 8'h20 : b;
      STR_OP_LOWER: return up ? b + 8'h20 : b;
      STR_OP_SWAP:  return lo ? b - 8'h20 : (up ? b + 8'h20 : b);
      default:      return b;
    endcase
  endfunction

  // Behavioural string unit; garbage when not enabled
  always_comb begin
    strop_result_i = 32'hDEAD_BEEF;
    if (strop_en_o)
      for (int i = 0; i < 4; i++)
        strop_result_i[8*i +: 8] = op_byte(strop_operator_o, strop_operand_o[8*i +: 8]);
  end

  // Memory: 4 KB window, aliased over the whole address space
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int  gnt_max = 0, rv_max = 1, err_read_n = 0;
  bit  gnt_block = 1'b0;
  int  rd_cnt = 0, wr_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_be_q[$];

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic poke_byte(input logic [31:0] a, input logic [7:0] b);
    mem[a[11:2]][8*a[1:0] +: 8] = b;
  endtask

  // Memory responder: random gnt and rvalid latency, request-hold checking
  initial begin
    logic [31:0] s_addr, s_wdata, rd_val;
    logic        s_we, do_err, ab;
    logic [3:0]  s_be;
    int          d;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    forever begin
      if (!data_req_o) begin @(negedge clk); continue; end
      s_addr = data_addr_o; s_we = data_we_o; s_be = data_be_o; s_wdata = data_wdata_o;
      d = $urandom_range(gnt_max, 0);
      ab = 1'b0;
      for (int k = 0; k < d || gnt_block; k++) begin
        @(negedge clk);
        if (!data_req_o) begin ab = 1'b1; break; end
        vectors++;
        if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== {s_addr, s_we, s_be, s_wdata}) begin
          miscompares++;
          $display("FAIL req_hold: got addr=%h we=%b be=%b wdata=%h, need addr=%h we=%b be=%b wdata=%h",
                   data_addr_o, data_we_o, data_be_o, data_wdata_o, s_addr, s_we, s_be, s_wdata);
        end
      end
      if (ab) continue;
      data_gnt_i = 1'b1;
      do_err = 1'b0;
      rd_val = $urandom;
      if (s_we) begin
        wr_cnt++;
        wr_addr_q.push_back(s_addr); wr_be_q.push_back(s_be); wr_data_q.push_back(s_wdata);
        for (int i = 0; i < 4; i++) if (s_be[i]) mem[s_addr[11:2]][8*i +: 8] = s_wdata[8*i +: 8];
      end else begin
        rd_cnt++;
        if (err_read_n == rd_cnt) do_err = 1'b1;
        else                      rd_val = mem[s_addr[11:2]];
      end
      @(negedge clk);
      data_gnt_i = 1'b0;
      d = $urandom_range(rv_max, 1);
      for (int k = 1; k < d; k++) @(negedge clk);
      vectors++;
      if (data_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL outstanding: req=%b while response pending, need 0", data_req_o);
      end
      data_rvalid_i = 1'b1; data_err_i = do_err; data_rdata_i = rd_val;
      @(negedge clk);
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
    end
  end

  // Reference: walk the string word by word over ref_mem
  task automatic model_cmd(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] addr, input int errn,
                           output int cnt, output bit er, output bit lim, output int rd, output int wr);
    logic [31:0] a, w;
    int n;
    a = {addr[31:2], 2'b00}; cnt = 0; er = 0; lim = 0; rd = 0; wr = 0;
    forever begin
      rd++;
      if (rd == errn) begin er = 1; break; end
      w = ref_mem[a[11:2]];
      n = 4;
      for (int i = 3; i >= 0; i--) if (w[8*i +: 8] == 8'h00) n = i;
      if (n == 0) break;
      wr++;
      for (int i = 0; i < n; i++) ref_mem[a[11:2]][8*i +: 8] = op_byte(op, w[8*i +: 8]);
      cnt++;
      if (n < 4) break;
      if (cnt == MAXW) begin lim = 1; break; end
      a = a + 32'd4;
    end
  endtask

  // Issue one command (called at a negedge with the DUT idle) and wait for done_o
  task automatic do_cmd(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] addr, output int lat);
    rd_cnt = 0; wr_cnt = 0;
    wr_addr_q.delete(); wr_be_q.delete(); wr_data_q.delete();
    start_i = 1'b1; operator_i = op; addr_i = addr;
    @(negedge clk);
    start_i = 1'b0; operator_i = STR_OP_WIDTH'($urandom); addr_i = $urandom;
    lat = 1;
    while (!done_o && lat < 500) begin @(negedge clk); lat++; end
    if (!done_o) begin
      miscompares++;
      $display("FAIL done_timeout: no done_o after %0d cycles", lat);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy_o, done_o, err_o, limit_o, count_o, data_req_o, data_addr_o, data_we_o, data_be_o,
         data_wdata_o, strop_en_o, strop_operator_o, strop_operand_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: outputs nonzero (req=%b busy=%b addr=%h) need all 0", data_req_o, busy_o, data_addr_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy_o, done_o, data_req_o, count_o, err_o, limit_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b done=%b req=%b count=%0d need 0", busy_o, done_o, data_req_o, count_o);
    end
  endtask

  task automatic test_single_word();
    int lat;
    mem[32'h100 >> 2] = 32'h0063_6261;
    do_cmd(STR_OP_UPPER, 32'h100, lat);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL single_latency: got %0d need 6", lat); end
    vectors++; if ({count_o, err_o, limit_o} !== {16'd1, 1'b0, 1'b0}) begin miscompares++;
      $display("FAIL single_status: count=%0d err=%b limit=%b need 1 0 0", count_o, err_o, limit_o); end
    vectors++; if ({rd_cnt, wr_cnt} !== {32'd1, 32'd1}) begin miscompares++;
      $display("FAIL single_txns: rd=%0d wr=%0d need 1 1", rd_cnt, wr_cnt); end
    if (wr_cnt == 1) begin
      vectors++; if ({wr_addr_q[0], wr_be_q[0], wr_data_q[0][23:0]} !== {32'h100, 4'b0111, 24'h434241}) begin
        miscompares++; $display("FAIL single_write: addr=%h be=%b wdata=%h need 100 0111 xx434241",
                                wr_addr_q[0], wr_be_q[0], wr_data_q[0]); end
    end
    vectors++; if (mem[32'h100 >> 2] !== 32'h0043_4241) begin miscompares++;
      $display("FAIL single_mem: got %h need 00434241", mem[32'h100 >> 2]); end
    @(negedge clk);
    vectors++; if ({done_o, busy_o} !== 2'b00) begin miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b a cycle later, need 0 0", done_o, busy_o); end
  endtask

  task automatic test_unaligned();
    int lat;
    mem[32'h200 >> 2] = 32'h6463_6261;
    mem[32'h204 >> 2] = 32'h0067_6665;
    mem[32'h208 >> 2] = 32'h1122_3344;
    do_cmd(STR_OP_UPPER, 32'h203, lat);
    vectors++; if (lat !== 11) begin miscompares++; $display("FAIL unaligned_latency: got %0d need 11", lat); end
    vectors++; if ({count_o, err_o, limit_o, rd_cnt, wr_cnt} !== {16'd2, 2'b00, 32'd2, 32'd2}) begin miscompares++;
      $display("FAIL unaligned_status: count=%0d err=%b limit=%b rd=%0d wr=%0d need 2 0 0 2 2",
               count_o, err_o, limit_o, rd_cnt, wr_cnt); end
    if (wr_cnt == 2) begin
      vectors++; if ({wr_addr_q[0], wr_be_q[0], wr_addr_q[1], wr_be_q[1]} !== {32'h200, 4'hF, 32'h204, 4'b0111}) begin
        miscompares++; $display("FAIL unaligned_writes: %h/%b %h/%b need 200/1111 204/0111",
                                wr_addr_q[0], wr_be_q[0], wr_addr_q[1], wr_be_q[1]); end
    end
    vectors++; if ({mem[32'h200 >> 2], mem[32'h204 >> 2], mem[32'h208 >> 2]} !== {32'h4443_4241, 32'h0047_4645, 32'h1122_3344}) begin
      miscompares++; $display("FAIL unaligned_mem: got %h %h %h need 44434241 00474645 11223344",
                              mem[32'h200 >> 2], mem[32'h204 >> 2], mem[32'h208 >> 2]); end
    @(negedge clk);
  endtask

  task automatic test_nul_first();
    int lat;
    mem[32'h300 >> 2] = 32'h4142_4300;
    do_cmd(STR_OP_LOWER, 32'h300, lat);
    vectors++; if ({lat, rd_cnt, wr_cnt, count_o, err_o} !== {32'd4, 32'd1, 32'd0, 16'd0, 1'b0}) begin miscompares++;
      $display("FAIL nul_first: lat=%0d rd=%0d wr=%0d count=%0d err=%b need 4 1 0 0 0", lat, rd_cnt, wr_cnt, count_o, err_o); end
    vectors++; if (mem[32'h300 >> 2] !== 32'h4142_4300) begin miscompares++;
      $display("FAIL nul_first_mem: got %h need 41424300", mem[32'h300 >> 2]); end
    @(negedge clk);
  endtask

  task automatic test_limit();
    int lat;
    mem[32'h400 >> 2] = 32'h4142_4344;
    mem[32'h404 >> 2] = 32'h4546_4748;
    mem[32'h408 >> 2] = 32'h494A_4B00;
    do_cmd(STR_OP_LOWER, 32'h400, lat);
    vectors++; if ({count_o, limit_o, err_o, rd_cnt, wr_cnt} !== {16'd2, 2'b10, 32'd2, 32'd2}) begin miscompares++;
      $display("FAIL limit_status: count=%0d limit=%b err=%b rd=%0d wr=%0d need 2 1 0 2 2",
               count_o, limit_o, err_o, rd_cnt, wr_cnt); end
    vectors++; if ({mem[32'h400 >> 2], mem[32'h404 >> 2], mem[32'h408 >> 2]} !== {32'h6162_6364, 32'h6566_6768, 32'h494A_4B00}) begin
      miscompares++; $display("FAIL limit_mem: got %h %h %h need 61626364 65666768 494a4b00",
                              mem[32'h400 >> 2], mem[32'h404 >> 2], mem[32'h408 >> 2]); end
    @(negedge clk);
    vectors++; if ({limit_o, count_o} !== {1'b1, 16'd2}) begin miscompares++;
      $display("FAIL limit_hold: limit=%b count=%0d after done, need 1 2", limit_o, count_o); end
  endtask

  task automatic test_read_error();
    int lat;
    mem[32'h500 >> 2] = 32'h6463_6261;
    mem[32'h504 >> 2] = 32'h0067_6665;
    err_read_n = 2;
    do_cmd(STR_OP_UPPER, 32'h500, lat);
    err_read_n = 0;
    vectors++; if ({err_o, limit_o, count_o, rd_cnt, wr_cnt} !== {2'b10, 16'd1, 32'd2, 32'd1}) begin miscompares++;
      $display("FAIL rderr_status: err=%b limit=%b count=%0d rd=%0d wr=%0d need 1 0 1 2 1",
               err_o, limit_o, count_o, rd_cnt, wr_cnt); end
    vectors++; if ({mem[32'h500 >> 2], mem[32'h504 >> 2]} !== {32'h4443_4241, 32'h0067_6665}) begin miscompares++;
      $display("FAIL rderr_mem: got %h %h need 44434241 00676665", mem[32'h500 >> 2], mem[32'h504 >> 2]); end
    vectors++; if (strop_operand_o !== 32'h6463_6261) begin miscompares++;
      $display("FAIL rderr_operand: got %h need 64636261", strop_operand_o); end
    @(negedge clk);
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL rderr_hold: err=%b need 1", err_o); end
  endtask

  task automatic test_reset_midreq();
    int lat, dones, cnt, rd, wr;
    bit er, lim;
    gnt_block = 1'b1;
    mem[32'h600 >> 2] = 32'h0000_6261;
    start_i = 1'b1; operator_i = STR_OP_UPPER; addr_i = 32'h600;
    @(negedge clk); start_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (data_req_o !== 1'b1) begin miscompares++; $display("FAIL midreq_pending: req=%b need 1", data_req_o); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (data_req_o !== 1'b0) begin miscompares++; $display("FAIL async_drop: req=%b need 0", data_req_o); end
    gnt_block = 1'b0;
    dones = 0;
    repeat (3) begin @(negedge clk); if (done_o) dones++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done_o) dones++; end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL reset_no_done: %0d done pulses need 0", dones); end
    foreach (ref_mem[i]) ref_mem[i] = mem[i];
    model_cmd(STR_OP_UPPER, 32'h600, 0, cnt, er, lim, rd, wr);
    do_cmd(STR_OP_UPPER, 32'h600, lat);
    vectors++; if ({count_o, err_o, limit_o, rd_cnt, wr_cnt} !== {CW'(cnt), er, lim, rd, wr} || mem_diffs() != 0) begin
      miscompares++; $display("FAIL post_reset_cmd: count=%0d rd=%0d wr=%0d diffs=%0d need %0d %0d %0d 0",
                              count_o, rd_cnt, wr_cnt, mem_diffs(), cnt, rd, wr); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, cnt, rd, wr, errn, p;
    bit er, lim;
    logic [31:0] a;
    logic [STR_OP_WIDTH-1:0] op;
    gnt_max = 5; rv_max = 5;
    for (int it = 0; it < 40; it++) begin
      a = (it == 7) ? 32'hFFFF_FFFC + $urandom_range(3, 0) : 32'h800 + 4 * $urandom_range(500, 0) + $urandom_range(3, 0);
      for (int i = 0; i < 12; i++) poke_byte({a[31:2], 2'b00} + i, 8'($urandom_range(255, 1)));
      p = $urandom_range(11, 0);
      if (p < 9) poke_byte({a[31:2], 2'b00} + p, 8'h00);
      op   = STR_OP_WIDTH'($urandom);
      errn = ($urandom_range(4, 0) == 0) ? $urandom_range(2, 1) : 0;
      foreach (ref_mem[i]) ref_mem[i] = mem[i];
      model_cmd(op, a, errn, cnt, er, lim, rd, wr);
      err_read_n = errn;
      do_cmd(op, a, lat);
      err_read_n = 0;
      vectors++;
      if ({count_o, err_o, limit_o, rd_cnt, wr_cnt} !== {CW'(cnt), er, lim, rd, wr}) begin miscompares++;
        $display("FAIL random_status it=%0d: count=%0d err=%b limit=%b rd=%0d wr=%0d need %0d %b %b %0d %0d",
                 it, count_o, err_o, limit_o, rd_cnt, wr_cnt, cnt, er, lim, rd, wr); end
      vectors++;
      if (mem_diffs() != 0) begin miscompares++;
        $display("FAIL random_mem it=%0d: %0d words differ, need 0", it, mem_diffs()); end
      @(negedge clk);
    end
    gnt_max = 0; rv_max = 1;
  endtask

  task automatic test_back_to_back();
    int lat, n, cnt, rd, wr;
    bit er, lim;
    mem[32'h700 >> 2] = 32'h0063_6261;
    mem[32'h900 >> 2] = 32'h6162_6364;
    mem[32'h904 >> 2] = 32'h0000_0065;
    foreach (ref_mem[i]) ref_mem[i] = mem[i];
    model_cmd(STR_OP_SWAP, 32'h700, 0, cnt, er, lim, rd, wr);
    rd_cnt = 0; wr_cnt = 0;
    start_i = 1'b1; operator_i = STR_OP_SWAP; addr_i = 32'h700;
    @(negedge clk);
    // Strobes while busy must be dropped, not queued
    operator_i = STR_OP_COPY; addr_i = 32'h900;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    vectors++;
    if ({count_o, rd_cnt, wr_cnt, busy_o} !== {CW'(cnt), rd, wr, 1'b0} || mem_diffs() != 0) begin miscompares++;
      $display("FAIL busy_ignore: count=%0d rd=%0d wr=%0d busy=%b diffs=%0d need %0d %0d %0d 0 0",
               count_o, rd_cnt, wr_cnt, busy_o, mem_diffs(), cnt, rd, wr); end
    model_cmd(STR_OP_UPPER, 32'h900, 0, cnt, er, lim, rd, wr);
    do_cmd(STR_OP_UPPER, 32'h900, lat);
    @(negedge clk);
    model_cmd(STR_OP_LOWER, 32'h900, 0, cnt, er, lim, rd, wr);
    do_cmd(STR_OP_LOWER, 32'h900, lat);
    vectors++;
    if ({count_o, err_o, limit_o, rd_cnt, wr_cnt} !== {CW'(cnt), er, lim, rd, wr} || mem_diffs() != 0) begin miscompares++;
      $display("FAIL back_to_back: count=%0d rd=%0d wr=%0d diffs=%0d need %0d %0d %0d 0",
               count_o, rd_cnt, wr_cnt, mem_diffs(), cnt, rd, wr); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; operator_i = '0; addr_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_single_word();
    test_unaligned();
    test_nul_first();
    test_limit();
    test_read_error();
    test_reset_midreq();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
